demux_rr_sched: RTL and testbench
=================================

// Module: demux_rr_sched
// PURPOSE
//  Round-robin scheduler for the 1-to-4 demux. It distributes one input stream (valid/ready)
//  across four consumers and drives the demux select. Ownership is granted in bursts of up
//  to BURST beats. A consumer that stalls too long loses the grant.
//  Sits between a single producer and four consumer queues.
// PARAMETERS
//  DW         8   data width of in_data/out_data
//  BURST      4   max beats per grant before rotating (>=1)
//  STALL_MAX  15  cycles with in_valid=1 and granted out_ready=0 before forced release (>=1)
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        asynchronous active-low reset
//  en         in   1        1 = new grants allowed; 0 = no new grant (current burst completes)
//  in_valid   in   1        producer beat valid
//  in_data    in   DW       producer beat data
//  in_last    in   1        beat ends the burst early (sampled on handshake)
//  in_ready   out  1        producer may advance
//  out_ready  in   4        per-consumer ready
//  out_valid  out  4        per-consumer valid, one-hot or zero
//  out_data   out  DW       shared data bus = in_data (combinational pass-through)
//  S          out  2        demux select = currently/last granted consumer
//  busy       out  1        1 while in XFER
//  stall_drop out  1        1-cycle pulse when a grant is released by stall timeout
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, S=2'b00, last_grant=2'b11, beat_cnt=0, stall_cnt=0;
//   in_ready=0, out_valid=4'b0000, busy=0, stall_drop=0. Any burst in progress is abandoned.
//  Handshake: beat transfers when in_valid & in_ready. in_ready = (state==XFER) & out_ready[S].
//   out_valid = (state==XFER & in_valid) ? (4'b0001<<S) : 4'b0000. in_data must be stable
//   while in_valid=1 and in_ready=0.
//  FSM:
//   IDLE: if en & in_valid & |out_ready -> winner = first set bit of out_ready scanning
//    last_grant+1, +2, +3, +4 (mod 4). Register S=winner, last_grant=winner, beat_cnt=0,
//    stall_cnt=0, go XFER. Arbitration costs exactly 1 cycle (in_ready=0 in IDLE).
//    Otherwise stay; S holds its value.
//   XFER, on handshake: beat_cnt++, stall_cnt=0. If in_last or beat_cnt==BURST-1 -> IDLE.
//   XFER, in_valid=1 & out_ready[S]=0: stall_cnt++. At stall_cnt==STALL_MAX-1 -> IDLE,
//    stall_drop=1 for one cycle; no beat lost (beat not accepted).
//   XFER, in_valid=0: counters hold; stay (no timeout while producer idle).
//  en=0 has no effect in XFER; the burst finishes normally or by timeout.
//  Counter widths: beat_cnt clog2(BURST)+1, stall_cnt clog2(STALL_MAX)+1; neither wraps.
//  Simultaneous last beat + timeout threshold in the same cycle: handshake wins; no stall_drop.
//  out_ready change during XFER affects in_ready the same cycle; the grant does not move.
//  Throughput: max BURST beats per BURST+1 cycles.
// STRUCTURE
//  Package demux_sched_pkg: state enum {IDLE, XFER}, N_OUT=4, SEL_W=2, rotate-left function.
//  Sub-module rr_arb4: combinational 4-way rotating-priority arbiter
//   (req[3:0], last[1:0] -> gnt_valid, gnt_idx[1:0]).
//  Top: FSM + counters + one-hot decode of S for out_valid.
// TESTING
//  1 Reset: rst_n=0 mid-XFER -> same cycle out_valid=0, in_ready=0, busy=0, S=0.
//  2 Round-robin: out_ready=4'b1111, in_valid=1 steady, BURST=4 -> grants 0,1,2,3,0;
//    4 beats each, 1 idle cycle between.
//  3 Skip: out_ready=4'b1010, last_grant=1 -> next grant S=3, then S=1.
//  4 Early end: in_last on 2nd beat -> IDLE after 2 beats; next grant rotates.
//  5 Stall: grant S=2, then out_ready[2]=0 with in_valid=1 for 15 cycles -> stall_drop pulse,
//    IDLE. Re-arbitration picks 3 if ready; no data beat lost or duplicated.
//  6 en=0 mid-burst -> burst completes. IDLE holds with in_valid=1 until en=1.
//    Then 1-cycle arbitration.

Source files
------------

// File: rtl/demux_sched_pkg.sv
// demux_sched_pkg: shared types, sizes and helpers for the round-robin demux scheduler.
package demux_sched_pkg;
  typedef enum logic {IDLE, XFER} state_t;
  localparam int N_OUT = 4;
  localparam int SEL_W = 2;
  function automatic logic [N_OUT-1:0] rotl(input logic [N_OUT-1:0] v, input logic [SEL_W-1:0] n);
    logic [2*N_OUT-1:0] d;
    d = {v, v} << n;
    return d[2*N_OUT-1 -: N_OUT];
  endfunction
endpackage

// File: rtl/rr_arb4.sv
// rr_arb4: combinational 4-way arbiter, priority starts just after the last grant.
module rr_arb4
  import demux_sched_pkg::*;
(
  input  logic [N_OUT-1:0] i_req,
  input  logic [SEL_W-1:0] i_last,
  output logic             o_gnt_valid,
  output logic [SEL_W-1:0] o_gnt_idx
);
  logic [SEL_W-1:0] w_start, w_pos;
  logic [N_OUT-1:0] w_rot;
  assign w_start = i_last + 2'd1;
  // Rotate right by w_start so bit 0 is the highest-priority requester
  assign w_rot = rotl(i_req, 2'd0 - w_start);
  assign w_pos = w_rot[0] ? 2'd0 : w_rot[1] ? 2'd1 : w_rot[2] ? 2'd2 : 2'd3;
  assign o_gnt_idx = w_start + w_pos;
  assign o_gnt_valid = |i_req;
endmodule

// File: rtl/demux_rr_sched.sv
// demux_rr_sched: steers one valid/ready stream to four consumers in round-robin bursts,
// releasing a grant early on in_last, after BURST beats, or when the consumer stalls too long.
module demux_rr_sched
  import demux_sched_pkg::*;
#(
  parameter int DW        = 8,
  parameter int BURST     = 4,
  parameter int STALL_MAX = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  input  logic [DW-1:0]    in_data,
  input  logic             in_last,
  output logic             in_ready,
  input  logic [N_OUT-1:0] out_ready,
  output logic [N_OUT-1:0] out_valid,
  output logic [DW-1:0]    out_data,
  output logic [SEL_W-1:0] S,
  output logic             busy,
  output logic             stall_drop
);
  localparam int BW = $clog2(BURST) + 1;
  localparam int SW = $clog2(STALL_MAX) + 1;
  state_t           r_state, w_state_nxt;
  logic [SEL_W-1:0] r_s, r_last, w_s_nxt, w_last_nxt, w_gnt_idx;
  logic [BW-1:0]    r_beat, w_beat_nxt;
  logic [SW-1:0]    r_stall, w_stall_nxt;
  logic             w_gnt_valid, w_xfer, w_hs, w_stalled, w_timeout;

  rr_arb4 u_arb (
    .i_req       (out_ready),
    .i_last      (r_last),
    .o_gnt_valid (w_gnt_valid),
    .o_gnt_idx   (w_gnt_idx)
  );

  assign w_xfer     = r_state == XFER;
  assign w_hs       = w_xfer && in_valid && out_ready[r_s];
  assign w_stalled  = w_xfer && in_valid && !out_ready[r_s];
  assign w_timeout  = w_stalled && r_stall == SW'(STALL_MAX - 1);
  assign in_ready   = w_xfer && out_ready[r_s];
  assign out_valid  = (w_xfer && in_valid) ? rotl(4'b0001, r_s) : '0;
  assign out_data   = in_data;
  assign S          = r_s;
  assign busy       = w_xfer;
  assign stall_drop = w_timeout;

  always_comb begin
    w_state_nxt = r_state;
    w_s_nxt     = r_s;
    w_last_nxt  = r_last;
    w_beat_nxt  = r_beat;
    w_stall_nxt = r_stall;
    if (!w_xfer) begin
      if (en && in_valid && w_gnt_valid) begin
        w_state_nxt = XFER;
        w_s_nxt     = w_gnt_idx;
        w_last_nxt  = w_gnt_idx;
        w_beat_nxt  = '0;
        w_stall_nxt = '0;
      end
    end else if (w_hs) begin
      w_beat_nxt  = r_beat + 1'b1;
      w_stall_nxt = '0;
      w_state_nxt = (in_last || r_beat == BW'(BURST - 1)) ? IDLE : XFER;
    end else if (w_stalled) begin
      w_stall_nxt = r_stall + 1'b1;
      w_state_nxt = w_timeout ? IDLE : XFER;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_s     <= '0;
      r_last  <= 2'b11;
      r_beat  <= '0;
      r_stall <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_s     <= w_s_nxt;
      r_last  <= w_last_nxt;
      r_beat  <= w_beat_nxt;
      r_stall <= w_stall_nxt;
    end
  end
endmodule

// File: tb/tb_demux_rr_sched.sv
// tb_demux_rr_sched: directed stimulus with a scoreboard of expected (consumer, data) beats.
module tb_demux_rr_sched;
  logic       clk = 0, rst_n = 0, en = 1, in_valid = 0, in_last = 0;
  logic [7:0] in_data = 0, out_data;
  logic       in_ready, busy, stall_drop;
  logic [3:0] out_ready = 4'b1111, out_valid;
  logic [1:0] S;
  int total = 0, passed = 0, drop_cnt = 0, cyc = 0, sum = 0;
  logic [9:0] exp_q[$];

  demux_rr_sched dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .out_ready(out_ready), .out_valid(out_valid),
    .out_data(out_data), .S(S), .busy(busy), .stall_drop(stall_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic send(input logic [1:0] sel, input logic [7:0] d, input logic last, output int n);
    logic hs;
    exp_q.push_back({sel, d});
    in_valid = 1; in_data = d; in_last = last;
    n = 0;
    forever begin
      @(negedge clk); hs = in_ready;
      @(posedge clk); #1;
      n++;
      if (hs) break;
      if (n > 100) begin
        chk("send_timeout", n, 0);
        break;
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_drop) drop_cnt++;
      if (in_valid && in_ready) begin
        if (exp_q.size() == 0) chk("unexpected_beat", int'(out_data), -1);
        else begin
          logic [9:0] e;
          e = exp_q.pop_front();
          chk("beat_sel", int'(S), int'(e[9:8]));
          chk("beat_valid", int'(out_valid), int'(4'b0001 << e[9:8]));
          chk("beat_data", int'(out_data), int'(e[7:0]));
        end
      end
    end
  end

  initial begin
    #3;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_S", S, 0);
    chk("rst_drop", stall_drop, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    // Round-robin: grants 0,1,2,3,0 with 4 beats each and one arbitration cycle per burst
    sum = 0;
    for (int i = 0; i < 20; i++) begin
      send(2'((i / 4) % 4), 8'(8'h10 + i), 1'b0, cyc);
      sum += cyc;
    end
    chk("rr_cycles", sum, 25);
    // Skip non-ready consumers: last=0, grant 1 then 3 then 1
    out_ready = 4'b0010;
    send(2'd1, 8'h41, 1'b1, cyc);
    out_ready = 4'b1010;
    send(2'd3, 8'h42, 1'b1, cyc);
    send(2'd1, 8'h43, 1'b1, cyc);
    // Early end on 2nd beat, next grant rotates to 3
    out_ready = 4'b1111;
    send(2'd2, 8'h51, 1'b0, cyc);
    send(2'd2, 8'h52, 1'b1, cyc);
    send(2'd3, 8'h53, 1'b0, cyc);
    chk("early_rearb_cycles", cyc, 2);
    send(2'd3, 8'h54, 1'b1, cyc);
    in_valid = 0;
    // Stall timeout on consumer 2, pending beat goes to consumer 3 after release
    out_ready = 4'b0100;
    send(2'd2, 8'h61, 1'b0, cyc);
    out_ready = 4'b1000;
    drop_cnt = 0;
    send(2'd3, 8'h62, 1'b1, cyc);
    chk("stall_cycles", cyc, 17);
    chk("stall_drops", drop_cnt, 1);
    in_valid = 0;
    // en=0 mid-burst: burst completes, IDLE holds until en returns
    out_ready = 4'b1111;
    send(2'd0, 8'h71, 1'b0, cyc);
    en = 0;
    send(2'd0, 8'h72, 1'b0, cyc);
    send(2'd0, 8'h73, 1'b0, cyc);
    send(2'd0, 8'h74, 1'b0, cyc);
    in_data = 8'h75; in_last = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("en0_in_ready", in_ready, 0);
      chk("en0_busy", busy, 0);
    end
    @(posedge clk); #1 en = 1;
    send(2'd1, 8'h75, 1'b1, cyc);
    chk("en1_cycles", cyc, 2);
    // Asynchronous reset mid-XFER
    send(2'd2, 8'h81, 1'b0, cyc);
    out_ready = 4'b0000; in_data = 8'h82; in_last = 0;
    @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_S", S, 2);
    chk("pre_rst_valid", out_valid, 4'b0100);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_S", S, 0);
    in_valid = 0;
    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
